// File: rtl/debug_display.sv
// Probe display: shows one of CHANNELS probe words on active-low 7-segment digits,
// chosen manually or by auto-scroll, with a toggleable freeze snapshot.
module debug_display #(
    parameter int CHANNELS      = 8,
    parameter int WIDTH         = 16,
    parameter int SCROLL_PERIOD = 50_000_000,
    localparam int DIGITS = WIDTH / 4,
    localparam int SW     = $clog2(CHANNELS),
    localparam int CW     = $clog2(SCROLL_PERIOD)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CHANNELS*WIDTH-1:0] chan_i,
    input  logic [SW-1:0]             sel_i,
    input  logic                      mode_i,
    input  logic                      freeze_req_i,
    output logic [DIGITS*7-1:0]       hex_o,
    output logic [SW-1:0]             shown_chan_o,
    output logic                      frozen_o,
    output logic                      tick_o
);

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCROLL_PERIOD - 1);
    localparam logic [SW-1:0] CHAN_LAST = SW'(CHANNELS - 1);

    logic [SW-1:0]       shown_q, shown_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                frozen_q, frozen_d;
    logic [WIDTH-1:0]    snap_q, snap_d;
    logic                prev_q, prev_d;
    logic                armed_q, armed_d;
    logic                mode_prev_q, mode_prev_d;
    logic                tick_q, tick_d;
    logic [DIGITS*7-1:0] hex_q, hex_d;

    logic [WIDTH-1:0] chan_arr_s [CHANNELS];
    logic [WIDTH-1:0] live_s;
    logic [WIDTH-1:0] disp_s;
    logic             sel_ok_s;
    logic             frz_edge_s;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign chan_arr_s[c] = chan_i[c*WIDTH +: WIDTH];
    end

    // Segment order a..g from MSB to LSB, active low.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign sel_ok_s = ({1'b0, sel_i} < (SW+1)'(CHANNELS));
    // The key only arms after it has been seen low, so a key held through reset is ignored.
    assign frz_edge_s = freeze_req_i & ~prev_q & armed_q;

    // Next-state logic for selection, scroll counter, freeze and display.
    always_comb begin
        live_s      = chan_arr_s[shown_q];
        shown_d     = shown_q;
        cnt_d       = cnt_q;
        frozen_d    = frozen_q;
        snap_d      = snap_q;
        mode_prev_d = mode_prev_q;
        tick_d      = 1'b0;
        prev_d      = freeze_req_i;
        armed_d     = armed_q | ~freeze_req_i;

        if (frz_edge_s) begin
            frozen_d = ~frozen_q;
            if (!frozen_q) begin
                snap_d = live_s;
            end else begin
                snap_d = snap_q;
            end
        end else if (frozen_q) begin
            // mode_prev holds so a mode change made while frozen is seen at unfreeze
            frozen_d = 1'b1;
        end else begin
            mode_prev_d = mode_i;
            if (mode_i != mode_prev_q) begin
                cnt_d = '0;
                if (!mode_i && sel_ok_s) begin
                    shown_d = sel_i;
                end else begin
                    shown_d = shown_q;
                end
            end else if (mode_i) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                    shown_d = (shown_q == CHAN_LAST) ? '0 : shown_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
                if (sel_ok_s) begin
                    shown_d = sel_i;
                end else begin
                    shown_d = shown_q;
                end
            end
        end

        disp_s = frozen_q ? snap_q : live_s;
        hex_d  = '1;
        for (int k = 0; k < DIGITS; k++) begin
            hex_d[7*k +: 7] = seg7(disp_s[4*k +: 4]);
        end
    end

    // State and output registers; reset blanks the display.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shown_q     <= '0;
            cnt_q       <= '0;
            frozen_q    <= 1'b0;
            snap_q      <= '0;
            prev_q      <= 1'b0;
            armed_q     <= 1'b0;
            mode_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            hex_q       <= '1;
        end else begin
            shown_q     <= shown_d;
            cnt_q       <= cnt_d;
            frozen_q    <= frozen_d;
            snap_q      <= snap_d;
            prev_q      <= prev_d;
            armed_q     <= armed_d;
            mode_prev_q <= mode_prev_d;
            tick_q      <= tick_d;
            hex_q       <= hex_d;
        end
    end

    assign hex_o        = hex_q;
    assign shown_chan_o = shown_q;
    assign frozen_o     = frozen_q;
    assign tick_o       = tick_q;

endmodule

// File: tb/tb_debug_display.sv
// Scoreboard bench for debug_display with CHANNELS=4, WIDTH=16, SCROLL_PERIOD=4.
module tb_debug_display;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        int         cyc;
        logic [27:0] hex;
        logic [1:0]  shown;
        logic        frozen;
        logic        tick;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] chan;
    logic [1:0]  sel;
    logic        mode;
    logic        freeze;
    logic [27:0] hex;
    logic [1:0]  shown;
    logic        frozen;
    logic        tick;

    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    string tname = "init";
    exp_t  exp_q[$];

    debug_display #(.CHANNELS(4), .WIDTH(16), .SCROLL_PERIOD(4)) dut (
        .clk_i(clk), .rst_i(rst), .chan_i(chan), .sel_i(sel), .mode_i(mode),
        .freeze_req_i(freeze), .hex_o(hex), .shown_chan_o(shown),
        .frozen_o(frozen), .tick_o(tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [27:0] enc(input logic [15:0] v);
        logic [27:0] r;
        for (int k = 0; k < 4; k++) r[7*k +: 7] = SEG_TAB[v[4*k +: 4]];
        return r;
    endfunction

    task automatic expect_at(input int k, input logic [15:0] v, input int sh,
                             input logic fr, input logic tk);
        exp_t e;
        e.cyc = cyc + k; e.hex = enc(v); e.shown = 2'(sh);
        e.frozen = fr; e.tick = tk; e.name = tname;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string nm, input logic [27:0] h, input logic [1:0] sh,
                             input logic fr, input logic tk);
        vectors++;
        if (hex !== h || shown !== sh || frozen !== fr || tick !== tk) begin
            miscompares++;
            $display("FAIL %s: got hex=%h shown=%0d frozen=%0b tick=%0b, want hex=%h shown=%0d frozen=%0b tick=%0b",
                     nm, hex, shown, frozen, tick, h, sh, fr, tk);
        end
    endtask

    task automatic set_chan(input int c, input logic [15:0] v);
        chan[c*16 +: 16] = v;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: the DUT presents a registered sample every clock; compare any entries due now.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                vectors++;
                if (exp_q[i].cyc != cyc || hex !== exp_q[i].hex || shown !== exp_q[i].shown ||
                    frozen !== exp_q[i].frozen || tick !== exp_q[i].tick) begin
                    miscompares++;
                    $display("FAIL %s @cyc %0d (due %0d): got hex=%h shown=%0d frozen=%0b tick=%0b, want hex=%h shown=%0d frozen=%0b tick=%0b",
                             exp_q[i].name, cyc, exp_q[i].cyc, hex, shown, frozen, tick,
                             exp_q[i].hex, exp_q[i].shown, exp_q[i].frozen, exp_q[i].tick);
                end
                exp_q.delete(i);
            end
        end
    end

    initial begin
        chan = 64'hC0DE_BEEF_1A80_00FF;
        sel = 2'd0; mode = 1'b0; freeze = 1'b0;

        step(1);
        check_now("reset_state", 28'hFFFFFFF, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tname = "first_load";
        expect_at(1, 16'h00FF, 0, 1'b0, 1'b0);
        step(1);

        tname = "manual_sel";
        sel = 2'd1;
        expect_at(1, 16'h00FF, 1, 1'b0, 1'b0);
        expect_at(2, 16'h1A80, 1, 1'b0, 1'b0);
        step(2);

        tname = "chan_latency";
        set_chan(1, 16'h2468);
        expect_at(1, 16'h2468, 1, 1'b0, 1'b0);
        step(1);

        sel = 2'd2;
        expect_at(1, 16'h2468, 2, 1'b0, 1'b0);
        expect_at(2, 16'hBEEF, 2, 1'b0, 1'b0);
        step(2);

        tname = "auto_scroll";
        mode = 1'b1; sel = 2'd1;
        expect_at(1,  16'hBEEF, 2, 1'b0, 1'b0);
        expect_at(4,  16'hBEEF, 2, 1'b0, 1'b0);
        expect_at(5,  16'hBEEF, 3, 1'b0, 1'b1);
        expect_at(6,  16'hC0DE, 3, 1'b0, 1'b0);
        expect_at(9,  16'hC0DE, 0, 1'b0, 1'b1);
        expect_at(10, 16'h00FF, 0, 1'b0, 1'b0);
        expect_at(13, 16'h00FF, 1, 1'b0, 1'b1);
        expect_at(14, 16'h2468, 1, 1'b0, 1'b0);
        expect_at(17, 16'h2468, 2, 1'b0, 1'b1);
        expect_at(18, 16'hBEEF, 2, 1'b0, 1'b0);
        expect_at(20, 16'hBEEF, 2, 1'b0, 1'b0);
        step(20);

        tname = "collision_held_key";
        freeze = 1'b1;
        for (int k = 1; k <= 10; k++) expect_at(k, 16'hBEEF, 2, 1'b1, 1'b0);
        step(1);
        set_chan(2, 16'h1357); mode = 1'b0; sel = 2'd3;
        step(9);
        freeze = 1'b0;
        expect_at(1, 16'hBEEF, 2, 1'b1, 1'b0);
        step(1);
        tname = "unfreeze_mode_change";
        freeze = 1'b1;
        expect_at(1, 16'hBEEF, 2, 1'b0, 1'b0);
        expect_at(2, 16'h1357, 3, 1'b0, 1'b0);
        expect_at(3, 16'hC0DE, 3, 1'b0, 1'b0);
        step(1);
        freeze = 1'b0;
        step(2);

        tname = "freeze_snapshot";
        sel = 2'd0;
        expect_at(1, 16'hC0DE, 0, 1'b0, 1'b0);
        expect_at(2, 16'h00FF, 0, 1'b0, 1'b0);
        step(2);
        freeze = 1'b1;
        expect_at(1, 16'h00FF, 0, 1'b1, 1'b0);
        step(1);
        set_chan(0, 16'h1234); freeze = 1'b0;
        expect_at(1, 16'h00FF, 0, 1'b1, 1'b0);
        expect_at(2, 16'h00FF, 0, 1'b1, 1'b0);
        step(2);
        freeze = 1'b1;
        expect_at(1, 16'h00FF, 0, 1'b0, 1'b0);
        expect_at(2, 16'h1234, 0, 1'b0, 1'b0);
        step(1);
        freeze = 1'b0;
        step(1);

        tname = "frozen_ch3";
        sel = 2'd3;
        expect_at(2, 16'hC0DE, 3, 1'b0, 1'b0);
        step(2);
        freeze = 1'b1;
        expect_at(1, 16'hC0DE, 3, 1'b1, 1'b0);
        step(1);
        #2 rst = 1'b1; mode = 1'b1;
        #1 check_now("async_reset", 28'hFFFFFFF, 2'd0, 1'b0, 1'b0);
        step(1);

        tname = "release_key_held";
        rst = 1'b0;
        expect_at(1, 16'h1234, 0, 1'b0, 1'b0);
        expect_at(2, 16'h1234, 0, 1'b0, 1'b0);
        expect_at(3, 16'h1234, 0, 1'b0, 1'b0);
        expect_at(4, 16'h1234, 0, 1'b0, 1'b0);
        expect_at(5, 16'h1234, 1, 1'b0, 1'b1);
        expect_at(6, 16'h2468, 1, 1'b0, 1'b0);
        step(3);
        freeze = 1'b0;
        step(3);

        step(2);
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
